// File: rtl/track_pkg.sv
// Shared types and helpers for the track window update block.
// Optional feature macro TRACK_SMOOTH_EN is consumed by track_window_update.
package track_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2,
    CALC = 2'd3
  } state_t;

  typedef struct packed {
    coord_t left;
    coord_t right;
    coord_t top;
    coord_t bottom;
  } box_t;

  // Clamp a signed edge position into [0, hi].
  function automatic coord_t clamp(input logic signed [10:0] v, input logic signed [10:0] hi);
    coord_t r;
    if (v < 11'sd0) begin
      r = 10'd0;
    end else if (v > hi) begin
      r = hi[9:0];
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/box_clamp.sv
// Combinational search box around a target, kept fully on screen.
module box_clamp
  import track_pkg::*;
#(
  parameter int VGA_W    = 640,
  parameter int VGA_H    = 480,
  parameter int SEARCH_W = 32
) (
  input  coord_t target_x,
  input  coord_t target_y,
  output box_t   box
);

  localparam logic signed [10:0] HALF_S = 11'(SEARCH_W / 2);
  localparam logic signed [10:0] X_HI_S = 11'(VGA_W - SEARCH_W - 1);
  localparam logic signed [10:0] Y_HI_S = 11'(VGA_H - SEARCH_W - 1);

  logic signed [10:0] lx_s;
  logic signed [10:0] ty_s;
  coord_t             left_s;
  coord_t             top_s;

  assign lx_s   = $signed({1'b0, target_x}) - HALF_S;
  assign ty_s   = $signed({1'b0, target_y}) - HALF_S;
  assign left_s = clamp(lx_s, X_HI_S);
  assign top_s  = clamp(ty_s, Y_HI_S);

  assign box.left   = left_s;
  assign box.right  = left_s + 10'(SEARCH_W);
  assign box.top    = top_s;
  assign box.bottom = top_s + 10'(SEARCH_W);

endmodule

// File: rtl/track_window_update.sv
// Per-frame target update with jump rejection; publishes the search box on frame_start.
// Define TRACK_SMOOTH_EN to move the target halfway toward each accepted measurement.
module track_window_update
  import track_pkg::*;
#(
  parameter int VGA_W      = 640,
  parameter int VGA_H      = 480,
  parameter int SEARCH_W   = 32,
  parameter int MAX_JUMP   = 48,
  parameter int LOST_LIMIT = 8,
  parameter int INIT_X     = 200,
  parameter int INIT_Y     = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tracking_mode,
  input  logic       frame_start,
  input  logic       max_ready,
  input  logic [9:0] max_x,
  input  logic [9:0] max_y,
  output logic [9:0] left,
  output logic [9:0] right,
  output logic [9:0] top,
  output logic [9:0] bottom,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic       box_valid,
  output logic       lost
);

  localparam int CNT_W = $clog2(LOST_LIMIT + 1);

  state_t             state_r, state_nx_s;
  logic               prev_ready_r, rise_s;
  coord_t             meas_x_r, meas_y_r, target_x_r, target_y_r;
  coord_t             new_tx_s, new_ty_s;
  logic [CNT_W-1:0]   reject_cnt_r;
  logic               lost_r, accept_r, accept_s, pending_r, box_valid_r;
  logic signed [10:0] dx_s, dy_s;
  logic [10:0]        adx_s, ady_s;
  box_t               init_box_s, calc_box_s, shadow_r, box_r;

  box_clamp #(.VGA_W(VGA_W), .VGA_H(VGA_H), .SEARCH_W(SEARCH_W)) u_init_box (
    .target_x(10'(INIT_X)), .target_y(10'(INIT_Y)), .box(init_box_s));

  box_clamp #(.VGA_W(VGA_W), .VGA_H(VGA_H), .SEARCH_W(SEARCH_W)) u_calc_box (
    .target_x(new_tx_s), .target_y(new_ty_s), .box(calc_box_s));

  assign rise_s   = max_ready & ~prev_ready_r;
  assign dx_s     = $signed({1'b0, meas_x_r}) - $signed({1'b0, target_x_r});
  assign dy_s     = $signed({1'b0, meas_y_r}) - $signed({1'b0, target_y_r});
  assign adx_s    = dx_s[10] ? 11'(-dx_s) : 11'(dx_s);
  assign ady_s    = dy_s[10] ? 11'(-dy_s) : 11'(dy_s);
  assign accept_s = ((adx_s <= 11'(MAX_JUMP)) && (ady_s <= 11'(MAX_JUMP))) || lost_r;

`ifdef TRACK_SMOOTH_EN
  logic               reacq_r;
  logic signed [10:0] sm_x_s, sm_y_s;
  assign sm_x_s = $signed({1'b0, target_x_r}) + (dx_s >>> 1);
  assign sm_y_s = $signed({1'b0, target_y_r}) + (dy_s >>> 1);

  // Next target: reacquired measurements are taken directly, others are smoothed.
  always_comb begin
    new_tx_s = target_x_r;
    new_ty_s = target_y_r;
    if (accept_r && reacq_r) begin
      new_tx_s = meas_x_r;
      new_ty_s = meas_y_r;
    end else if (accept_r) begin
      new_tx_s = sm_x_s[9:0];
      new_ty_s = sm_y_s[9:0];
    end else begin
      new_tx_s = target_x_r;
      new_ty_s = target_y_r;
    end
  end

  // Remember whether the measurement under evaluation was a reacquisition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reacq_r <= 1'b0;
    end else if (!tracking_mode) begin
      reacq_r <= 1'b0;
    end else if (state_r == EVAL) begin
      reacq_r <= lost_r;
    end
  end
`else
  // Next target: an accepted measurement replaces the target outright.
  always_comb begin
    new_tx_s = target_x_r;
    new_ty_s = target_y_r;
    if (accept_r) begin
      new_tx_s = meas_x_r;
      new_ty_s = meas_y_r;
    end else begin
      new_tx_s = target_x_r;
      new_ty_s = target_y_r;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // FSM next state; dropping tracking_mode aborts from anywhere.
  always_comb begin
    state_nx_s = state_r;
    if (!tracking_mode) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = WAIT;
        WAIT:    state_nx_s = rise_s ? EVAL : WAIT;
        EVAL:    state_nx_s = CALC;
        CALC:    state_nx_s = WAIT;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Measurement latch, accept/reject bookkeeping, shadow box and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ready_r <= 1'b0;
      meas_x_r     <= 10'd0;
      meas_y_r     <= 10'd0;
      target_x_r   <= 10'(INIT_X);
      target_y_r   <= 10'(INIT_Y);
      reject_cnt_r <= '0;
      lost_r       <= 1'b0;
      accept_r     <= 1'b0;
      pending_r    <= 1'b0;
      box_valid_r  <= 1'b0;
      shadow_r     <= init_box_s;
      box_r        <= init_box_s;
    end else if (!tracking_mode) begin
      prev_ready_r <= max_ready;
      target_x_r   <= 10'(INIT_X);
      target_y_r   <= 10'(INIT_Y);
      reject_cnt_r <= '0;
      lost_r       <= 1'b0;
      accept_r     <= 1'b0;
      pending_r    <= 1'b0;
      box_valid_r  <= 1'b0;
      shadow_r     <= init_box_s;
      box_r        <= init_box_s;
    end else begin
      prev_ready_r <= max_ready;
      if (state_r == WAIT && rise_s) begin
        meas_x_r <= max_x;
        meas_y_r <= max_y;
      end
      if (state_r == EVAL) begin
        accept_r <= accept_s;
        if (accept_s) begin
          reject_cnt_r <= '0;
          lost_r       <= 1'b0;
        end else begin
          if (reject_cnt_r != CNT_W'(LOST_LIMIT)) reject_cnt_r <= reject_cnt_r + 1'b1;
          if (reject_cnt_r >= CNT_W'(LOST_LIMIT - 1)) lost_r <= 1'b1;
        end
      end
      if (state_r == CALC) begin
        target_x_r <= new_tx_s;
        target_y_r <= new_ty_s;
        shadow_r   <= calc_box_s;
      end
      if (frame_start && pending_r) begin
        box_r       <= shadow_r;
        box_valid_r <= 1'b1;
      end
      // A fresh shadow always outranks a simultaneous publish-clear.
      if (state_r == CALC)  pending_r <= 1'b1;
      else if (frame_start) pending_r <= 1'b0;
    end
  end

  assign left      = box_r.left;
  assign right     = box_r.right;
  assign top       = box_r.top;
  assign bottom    = box_r.bottom;
  assign target_x  = target_x_r;
  assign target_y  = target_y_r;
  assign box_valid = box_valid_r;
  assign lost      = lost_r;

endmodule

// File: tb/tb_track_window_update.sv
// Directed, table-driven bench for track_window_update (honours TRACK_SMOOTH_EN).
module tb_track_window_update;

  logic       clk = 1'b0;
  logic       rst_n, tracking_mode, frame_start, max_ready;
  logic [9:0] max_x, max_y;
  logic [9:0] left, right, top, bottom, target_x, target_y;
  logic       box_valid, lost;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [9:0] mx, my, l, r, t, b, tx, ty;
    logic       bv, lost;
  } vec_t;

  vec_t tbl[$];

  track_window_update dut (
    .clk(clk), .rst_n(rst_n), .tracking_mode(tracking_mode), .frame_start(frame_start),
    .max_ready(max_ready), .max_x(max_x), .max_y(max_y),
    .left(left), .right(right), .top(top), .bottom(bottom),
    .target_x(target_x), .target_y(target_y), .box_valid(box_valid), .lost(lost));

  always #5 clk = ~clk;

  function automatic vec_t mk(input int mx, my, l, r, t, b, tx, ty, bv, ls);
    vec_t v;
    v.mx = 10'(mx); v.my = 10'(my);
    v.l = 10'(l); v.r = 10'(r); v.t = 10'(t); v.b = 10'(b);
    v.tx = 10'(tx); v.ty = 10'(ty);
    v.bv = 1'(bv); v.lost = 1'(ls);
    return v;
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int l, r, t, b, tx, ty, bv, ls);
    chk({tag, ".left"}, left, 10'(l));
    chk({tag, ".right"}, right, 10'(r));
    chk({tag, ".top"}, top, 10'(t));
    chk({tag, ".bottom"}, bottom, 10'(b));
    chk({tag, ".target_x"}, target_x, 10'(tx));
    chk({tag, ".target_y"}, target_y, 10'(ty));
    chk({tag, ".box_valid"}, {9'd0, box_valid}, 10'(bv));
    chk({tag, ".lost"}, {9'd0, lost}, 10'(ls));
  endtask

  // One correlator result followed by one frame_start pulse.
  task automatic apply_meas(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    max_x = x; max_y = y; max_ready = 1'b1;
    repeat (5) @(negedge clk);
    max_ready = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply_meas(tbl[i].mx, tbl[i].my);
      chk_all($sformatf("row%0d", i), tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].b,
              tbl[i].tx, tbl[i].ty, tbl[i].bv, tbl[i].lost);
    end
  endtask

  initial begin
`ifdef TRACK_SMOOTH_EN
    tbl.push_back(mk(210, 190, 189, 221, 179, 211, 205, 195, 1, 0));
`else
    tbl.push_back(mk(210, 190, 194, 226, 174, 206, 210, 190, 1, 0));
`endif
    tbl.push_back(mk(200, 200, 184, 216, 184, 216, 200, 200, 1, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(300, 200, 184, 216, 184, 216, 200, 200, 1, (i == 8) ? 1 : 0));
    tbl.push_back(mk(300, 200, 284, 316, 184, 216, 300, 200, 1, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(5, 470, 284, 316, 184, 216, 300, 200, 1, (i == 8) ? 1 : 0));
    tbl.push_back(mk(5, 470, 0, 32, 447, 479, 5, 470, 1, 0));

    rst_n = 1'b0; tracking_mode = 1'b0; frame_start = 1'b0; max_ready = 1'b0;
    max_x = 10'd0; max_y = 10'd0;
    repeat (3) @(negedge clk);
    chk_all("reset", 184, 216, 184, 216, 200, 200, 0, 0);
    rst_n = 1'b1; tracking_mode = 1'b1;
    repeat (4) @(negedge clk);
    chk_all("idle", 184, 216, 184, 216, 200, 200, 0, 0);

    run_rows(0, 0);

    // tracking_mode dropped while the FSM is in EVAL.
    max_x = 10'd250; max_y = 10'd250; max_ready = 1'b1;
    @(negedge clk);
    tracking_mode = 1'b0; max_ready = 1'b0;
    @(negedge clk);
    chk_all("abort", 184, 216, 184, 216, 200, 200, 0, 0);
    tracking_mode = 1'b1;
    repeat (2) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    chk_all("abort_nopub", 184, 216, 184, 216, 200, 200, 0, 0);

    run_rows(1, tbl.size() - 1);

    // max_ready rise coincides with frame_start: publish deferred one frame.
    max_x = 10'd40; max_y = 10'd440; max_ready = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    max_ready = 1'b0;
    @(negedge clk);
`ifdef TRACK_SMOOTH_EN
    chk_all("simul_hold", 0, 32, 447, 479, 22, 455, 1, 0);
`else
    chk_all("simul_hold", 0, 32, 447, 479, 40, 440, 1, 0);
`endif
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
`ifdef TRACK_SMOOTH_EN
    chk_all("simul_pub", 6, 38, 439, 471, 22, 455, 1, 0);
`else
    chk_all("simul_pub", 24, 56, 424, 456, 40, 440, 1, 0);
`endif

    // Asynchronous reset while the FSM is in CALC.
    max_x = 10'd60; max_y = 10'd420; max_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 184, 216, 184, 216, 200, 200, 0, 0);
    @(negedge clk);
    max_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/track_window_update.md
Name: track_window_update

Overview:
Downstream of the correlator. Once per frame it takes the best-match coordinate (max_x/max_y, valid on the max_ready rising edge) and rejects implausible jumps. It then computes the next frame's search box (left/right/top/bottom), clamped to the screen. The box is held stable for the whole correlator scan and is only republished on the frame-start pulse, so the correlator never sees a box change mid-search.

Parameters:
VGA_W, 640, frame width in pixels
VGA_H, 480, frame height in pixels
SEARCH_W, 32, search box edge in pixels (matches correlator SEARCH_WIDTH)
MAX_JUMP, 48, max accepted |dx| or |dy| between consecutive matches, in pixels
LOST_LIMIT, 8, number of consecutive rejected frames before lost asserts
INIT_X, 200, target x at reset or when tracking is disabled
INIT_Y, 200, target y at reset or when tracking is disabled

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tracking_mode  in  1  1 = tracking enabled; 0 forces IDLE and re-initialises state
frame_start  in  1  one-cycle pulse at the start of each correlator scan (static BRAM ready rising edge)
max_ready  in  1  correlator result-valid level; rises once per scan
max_x  in  10  best-match x, sampled on max_ready rise
max_y  in  10  best-match y, sampled on max_ready rise
left, right, top, bottom  out  10 each  published search box
target_x, target_y  out  10 each  current accepted target position
box_valid  out  1  high once at least one measurement has been committed since init
lost  out  1  high after LOST_LIMIT consecutive rejected measurements

Behaviour:
- Reset / tracking_mode=0 (async reset; tracking_mode is synchronous):
  - target = (INIT_X, INIT_Y); box is computed from it (with defaults: left=184, right=216, top=184, bottom=216).
  - box_valid=0, lost=0, reject counter=0, pending=0, FSM=IDLE.
- max_ready rise detection: a registered copy of max_ready is kept; a rise is max_ready & ~prev.
- FSM states:
  - IDLE: go to WAIT when tracking_mode=1.
  - WAIT: on a max_ready rise, latch max_x/max_y and go to EVAL.
  - EVAL (1 cycle): form signed 11-bit dx = max_x - target_x and dy likewise.
    - accept if (|dx| ≤ MAX_JUMP and |dy| ≤ MAX_JUMP) or lost=1 (reacquire mode).
    - on accept: clear reject counter and lost.
    - on reject: increment reject counter (saturating); assert lost when it reaches LOST_LIMIT; target unchanged.
  - CALC (1 cycle): compute the new target and the candidate box into shadow registers, set pending=1, return to WAIT.
- Box arithmetic, signed 11-bit:
  - L = target_x - SEARCH_W/2, clamped to [0, VGA_W-SEARCH_W-1]; right = L + SEARCH_W.
  - top and bottom are computed the same way against VGA_H.
  - Clamp boundaries: target_x=5 gives left=0, right=32; target_x=630 gives left=607, right=639.
- Publish:
  - On frame_start with pending=1: copy the shadow box to left/right/top/bottom, set box_valid=1, clear pending. The outputs change the cycle after the pulse.
  - frame_start with pending=0: box unchanged.
  - A rejected measurement still republishes the same box, which harmlessly clears pending.
- Simultaneous events:
  - frame_start during EVAL/CALC: publish waits for the next frame_start; the in-flight update completes normally.
  - A max_ready rise outside WAIT is ignored.
  - tracking_mode falling mid-FSM: abort to IDLE and re-initialise on the next edge.
- Latency: max_ready rise to shadow ready is 3 cycles. Worst-case publish latency is one frame.

Optional Feature:
- Macro: TRACK_SMOOTH_EN.
- Defined: an accepted target is updated as target + (meas - target) >>> 1 (arithmetic shift, rounding toward -inf).
  - Example: target 200, meas 210 gives 205.
  - In reacquire mode (lost=1) the measurement is taken directly, unsmoothed.
- Undefined: target = meas on accept.

Decomposition:
- Shared package track_pkg: state enum (IDLE, WAIT, EVAL, CALC), box_t struct {left, right, top, bottom}, coordinate typedef coord_t = logic [9:0], and a clamp function.
- One sub-module: box_clamp, combinational. Computes box_t from target_x/target_y using the parameters. Instantiated once for the shadow box and once for the reset/initial box.

Test Plan:
- Reset, then tracking_mode=1 with no results → box 184/216/184/216, box_valid=0, lost=0.
- max_x=210, max_y=190 (dx=10, dy=-10), then frame_start → left=194, right=226, top=174, bottom=206, box_valid=1 (TRACK_SMOOTH_EN: target 205/195, left=189).
- max_x=5, max_y=470 accepted in reacquire mode → left=0, right=32, top=447, bottom=479.
- From target 200/200, 8 consecutive results at x=300 → box unchanged, lost rises on the 8th. A 9th result at x=300 is accepted: lost=0, left=284.
- max_ready rise and frame_start in the same cycle → box unchanged that frame; the new box publishes at the next frame_start.
- tracking_mode dropped mid-EVAL → next cycle target=200/200, box_valid=0, FSM=IDLE; asynchronous rst_n mid-CALC clears immediately.
